// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: load/store sequencer between the MEM stage and a word-addressed,
// byte-masked data memory. One request in flight at a time; accesses that cross
// a word boundary take two memory cycles; faults complete without touching memory.
// All outputs are registered: the next-cycle value of every output is computed
// in the combinational block and loaded together with the state.
module lsu_mem_ctrl #(
   parameter int ADDR_WIDTH = 15,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [1:0]            req_size,
   input  logic                  req_unsigned,
   input  logic [31:0]           req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  resp_valid,
   output logic                  resp_err,
   output logic [DATA_WIDTH-1:0] resp_rdata,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   output logic [3:0]            mem_wmask,
   output logic                  mem_we,
   input  logic [DATA_WIDTH-1:0] mem_rdata
);

   typedef enum logic [1:0] {IDLE, ACC0, ACC1, DONE} state_t;

   state_t                state_q, state_d;
   logic                  we_q, we_d;
   logic                  uns_q, uns_d;
   logic [2:0]            n_q, n_d;
   logic [1:0]            off_q, off_d;
   logic                  span_q, span_d;
   logic [ADDR_WIDTH-1:0] w0_q, w0_d;
   logic [31:0]           wdata_q, wdata_d;
   logic [31:0]           lo_q, lo_d;

   logic                  req_ready_q, req_ready_d;
   logic                  resp_valid_q, resp_valid_d;
   logic                  resp_err_q, resp_err_d;
   logic [31:0]           resp_rdata_q, resp_rdata_d;
   logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
   logic [31:0]           mem_wdata_q, mem_wdata_d;
   logic [3:0]            mem_wmask_q, mem_wmask_d;
   logic                  mem_we_q, mem_we_d;

   logic [2:0]            req_n;
   logic                  req_span;
   logic [ADDR_WIDTH-1:0] req_w0;
   logic                  req_oob;
   logic                  req_fault;

   // Byte-enable pattern for an access of n bytes starting at lane 0.
   function automatic logic [3:0] base_mask(input logic [2:0] n);
      case (n)
         3'd1:    base_mask = 4'b0001;
         3'd2:    base_mask = 4'b0011;
         default: base_mask = 4'b1111;
      endcase
   endfunction

   // Pick the addressed bytes out of the {hi,lo} word pair and extend to 32 bits.
   function automatic logic [31:0] extend_load(input logic [63:0] pair, input logic [1:0] off,
                                               input logic [2:0] n, input logic uns);
      logic [31:0] raw;
      raw = 32'(pair >> (8 * off));
      case (n)
         3'd1:    extend_load = {{24{~uns & raw[7]}}, raw[7:0]};
         3'd2:    extend_load = {{16{~uns & raw[15]}}, raw[15:0]};
         default: extend_load = raw;
      endcase
   endfunction

   // Decode the incoming request: size in bytes, word-crossing and fault checks.
   always_comb begin
      case (req_size)
         2'd0:    req_n = 3'd1;
         2'd1:    req_n = 3'd2;
         default: req_n = 3'd4;
      endcase
      req_span  = ({2'b00, req_addr[1:0]} + {1'b0, req_n}) > 4'd4;
      req_w0    = req_addr[ADDR_WIDTH+1:2];
      req_oob   = (req_addr >> (ADDR_WIDTH + 2)) != 32'd0;
      req_fault = (req_size == 2'd3) || req_oob ||
                  (req_span && (req_w0 == {ADDR_WIDTH{1'b1}}));
   end

   // Next state, captured request and next-cycle output values.
   always_comb begin
      state_d      = state_q;
      we_d         = we_q;
      uns_d        = uns_q;
      n_d          = n_q;
      off_d        = off_q;
      span_d       = span_q;
      w0_d         = w0_q;
      wdata_d      = wdata_q;
      lo_d         = lo_q;
      req_ready_d  = 1'b0;
      resp_valid_d = 1'b0;
      resp_err_d   = 1'b0;
      resp_rdata_d = 32'd0;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      mem_wmask_d  = 4'b0000;
      mem_we_d     = 1'b0;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               we_d    = req_we;
               uns_d   = req_unsigned;
               n_d     = req_n;
               off_d   = req_addr[1:0];
               span_d  = req_span;
               w0_d    = req_w0;
               wdata_d = req_wdata;
               if (req_fault) begin
                  state_d      = DONE;
                  resp_valid_d = 1'b1;
                  resp_err_d   = 1'b1;
               end else begin
                  state_d    = ACC0;
                  mem_addr_d = req_w0;
                  if (req_we) begin
                     mem_we_d    = 1'b1;
                     mem_wmask_d = base_mask(req_n) << req_addr[1:0];
                     mem_wdata_d = req_wdata << (8 * req_addr[1:0]);
                  end
               end
            end else begin
               req_ready_d = 1'b1;
            end
         end
         ACC0: begin
            if (span_q) begin
               state_d    = ACC1;
               lo_d       = mem_rdata;
               mem_addr_d = w0_q + ADDR_WIDTH'(1);
               if (we_q) begin
                  mem_we_d    = 1'b1;
                  mem_wmask_d = base_mask(n_q) >> (3'd4 - {1'b0, off_q});
                  mem_wdata_d = wdata_q >> (8 * (3'd4 - {1'b0, off_q}));
               end
            end else begin
               state_d      = DONE;
               resp_valid_d = 1'b1;
               resp_rdata_d = we_q ? 32'd0 : extend_load({32'd0, mem_rdata}, off_q, n_q, uns_q);
            end
         end
         ACC1: begin
            state_d      = DONE;
            resp_valid_d = 1'b1;
            resp_rdata_d = we_q ? 32'd0 : extend_load({mem_rdata, lo_q}, off_q, n_q, uns_q);
         end
         default: begin
            state_d     = IDLE;
            req_ready_d = 1'b1;
         end
      endcase
   end

   // State and output registers; reset abandons any access in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         we_q         <= 1'b0;
         uns_q        <= 1'b0;
         n_q          <= 3'd0;
         off_q        <= 2'd0;
         span_q       <= 1'b0;
         w0_q         <= '0;
         wdata_q      <= 32'd0;
         lo_q         <= 32'd0;
         req_ready_q  <= 1'b1;
         resp_valid_q <= 1'b0;
         resp_err_q   <= 1'b0;
         resp_rdata_q <= 32'd0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= 32'd0;
         mem_wmask_q  <= 4'b0000;
         mem_we_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         we_q         <= we_d;
         uns_q        <= uns_d;
         n_q          <= n_d;
         off_q        <= off_d;
         span_q       <= span_d;
         w0_q         <= w0_d;
         wdata_q      <= wdata_d;
         lo_q         <= lo_d;
         req_ready_q  <= req_ready_d;
         resp_valid_q <= resp_valid_d;
         resp_err_q   <= resp_err_d;
         resp_rdata_q <= resp_rdata_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         mem_wmask_q  <= mem_wmask_d;
         mem_we_q     <= mem_we_d;
      end
   end

   assign req_ready  = req_ready_q;
   assign resp_valid = resp_valid_q;
   assign resp_err   = resp_err_q;
   assign resp_rdata = resp_rdata_q;
   assign mem_addr   = mem_addr_q;
   assign mem_wdata  = mem_wdata_q;
   assign mem_wmask  = mem_wmask_q;
   assign mem_we     = mem_we_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb_lsu_mem_ctrl: drives lsu_mem_ctrl against a word memory and checks it
// against a byte-array reference memory that models loads/stores directly.
module tb_lsu_mem_ctrl;

   localparam int AW      = 15;
   localparam int NWORDS  = 1 << AW;
   localparam int NBYTESM = NWORDS * 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic          req_we = 1'b0;
   logic [1:0]    req_size = 2'd0;
   logic          req_unsigned = 1'b0;
   logic [31:0]   req_addr = 32'd0;
   logic [31:0]   req_wdata = 32'd0;
   logic          resp_valid;
   logic          resp_err;
   logic [31:0]   resp_rdata;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_wdata;
   logic [3:0]    mem_wmask;
   logic          mem_we;
   logic [31:0]   mem_rdata;

   logic [31:0]   memWords [0:NWORDS-1];
   logic [7:0]    refBytes [0:NBYTESM-1];
   logic [31:0]   wrWord;

   int            total = 0;
   int            bad = 0;
   int            lastLat;
   int            lastNumWr;
   logic          lastErr;
   logic [31:0]   lastRdata;
   logic [AW-1:0] wrAddr [2];
   logic [3:0]    wrMask [2];
   logic [31:0]   wrData [2];

   lsu_mem_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
      .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_err(resp_err),
      .resp_rdata(resp_rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_wmask(mem_wmask), .mem_we(mem_we), .mem_rdata(mem_rdata)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   // Data memory: combinational read, byte-masked write on the rising edge.
   assign mem_rdata = memWords[mem_addr];
   always @(posedge clk) begin
      if (mem_we) begin
         wrWord = memWords[mem_addr];
         for (int b = 0; b < 4; b++)
            if (mem_wmask[b]) wrWord[8*b +: 8] = mem_wdata[8*b +: 8];
         memWords[mem_addr] <= wrWord;
      end
   end

   function automatic int sizeBytes(input logic [1:0] s);
      return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
   endfunction

   // A request faults if its size is illegal or any byte lies past the end of memory.
   function automatic logic isFault(input logic [1:0] s, input logic [31:0] a);
      longint lastByte;
      if (s == 2'd3) return 1'b1;
      lastByte = longint'({32'd0, a}) + longint'(sizeBytes(s)) - 1;
      return lastByte >= longint'(NBYTESM);
   endfunction

   function automatic logic [31:0] refWord(input int w);
      return {refBytes[4*w+3], refBytes[4*w+2], refBytes[4*w+1], refBytes[4*w]};
   endfunction

   // Little-endian gather of n bytes, then sign or zero extension.
   function automatic logic [31:0] modelLoad(input logic [1:0] s, input logic uns, input logic [31:0] a);
      logic [31:0] v;
      int n;
      v = 32'd0;
      n = sizeBytes(s);
      for (int i = 0; i < n; i++) v[8*i +: 8] = refBytes[int'(a) + i];
      if (!uns && v[8*n-1])
         for (int i = 8 * n; i < 32; i++) v[i] = 1'b1;
      return v;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
      end
   endtask

   // Issue one request, follow it to its response and check timing, data and memory effects.
   task automatic applyStimulus(input string tag, input logic we, input logic [1:0] size,
                                input logic uns, input logic [31:0] addr, input logic [31:0] wdata);
      int          cyc;
      int          n;
      logic        expFault;
      int          expLat;
      logic [31:0] expData;
      n        = sizeBytes(size);
      expFault = isFault(size, addr);
      expLat   = expFault ? 1 : (((addr >> 2) != ((addr + 32'(n) - 1) >> 2)) ? 3 : 2);
      expData  = (expFault || we) ? 32'd0 : modelLoad(size, uns, addr);
      @(negedge clk);
      cyc = 0;
      while (!req_ready && cyc < 8) begin
         @(negedge clk);
         cyc++;
      end
      checkOutput({tag, " ready"}, 32'(req_ready), 32'd1);
      req_valid    = 1'b1;
      req_we       = we;
      req_size     = size;
      req_unsigned = uns;
      req_addr     = addr;
      req_wdata    = wdata;
      @(posedge clk);
      #1;
      req_valid    = 1'b0;
      req_we       = 1'($urandom);
      req_size     = 2'($urandom);
      req_unsigned = 1'($urandom);
      req_addr     = $urandom;
      req_wdata    = $urandom;
      cyc          = 1;
      lastNumWr    = 0;
      while (cyc <= 6) begin
         if (mem_we) begin
            if (lastNumWr < 2) begin
               wrAddr[lastNumWr] = mem_addr;
               wrMask[lastNumWr] = mem_wmask;
               wrData[lastNumWr] = mem_wdata;
            end
            lastNumWr++;
         end
         if (resp_valid) break;
         @(posedge clk);
         #1;
         cyc++;
      end
      lastLat   = cyc;
      lastErr   = resp_err;
      lastRdata = resp_rdata;
      checkOutput({tag, " latency"}, 32'(cyc), 32'(expLat));
      checkOutput({tag, " err"}, 32'(resp_err), 32'(expFault));
      checkOutput({tag, " rdata"}, resp_rdata, expData);
      checkOutput({tag, " writes"}, 32'(lastNumWr), (expFault || !we) ? 32'd0 : 32'(expLat - 1));
      @(posedge clk);
      #1;
      checkOutput({tag, " pulse"}, 32'(resp_valid), 32'd0);
      checkOutput({tag, " idle"}, 32'(req_ready), 32'd1);
      if (!expFault && we) begin
         for (int i = 0; i < n; i++) refBytes[int'(addr) + i] = wdata[8*i +: 8];
         for (int w = int'(addr >> 2); w <= int'((addr + 32'(n) - 1) >> 2); w++)
            checkOutput({tag, " memword"}, memWords[w], refWord(w));
      end
   endtask

   // Reset in the middle of a split store: no write may reach either word.
   task automatic resetDuringSplit();
      @(negedge clk);
      req_valid    = 1'b1;
      req_we       = 1'b1;
      req_size     = 2'd2;
      req_unsigned = 1'b0;
      req_addr     = 32'h206;
      req_wdata    = 32'hA5C3_F00D;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      checkOutput("rst acc0 we", 32'(mem_we), 32'd1);
      rst_n = 1'b0;
      #1;
      checkOutput("rst ready", 32'(req_ready), 32'd1);
      checkOutput("rst we", 32'(mem_we), 32'd0);
      checkOutput("rst mask", 32'(mem_wmask), 32'd0);
      checkOutput("rst addr", 32'(mem_addr), 32'd0);
      checkOutput("rst resp", 32'(resp_valid), 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst word0", memWords[32'h81], refWord(32'h81));
      checkOutput("rst word1", memWords[32'h82], refWord(32'h82));
      checkOutput("rst idle resp", 32'(resp_valid), 32'd0);
   endtask

   // Loads with req_valid held high: one response per request, in order.
   task automatic backToBack(input int nReq);
      logic [31:0] expQ [$];
      int          issued;
      int          got;
      int          cyc;
      int          extra;
      logic [31:0] a;
      logic [1:0]  s;
      logic        u;
      issued = 0;
      got    = 0;
      cyc    = 0;
      extra  = 0;
      @(negedge clk);
      while (got < nReq && cyc < 40 * nReq) begin
         if (resp_valid) begin
            checkOutput("b2b ready low", 32'(req_ready), 32'd0);
            checkOutput("b2b queued", 32'(expQ.size() > 0), 32'd1);
            if (expQ.size() > 0) checkOutput("b2b rdata", resp_rdata, expQ.pop_front());
            checkOutput("b2b err", 32'(resp_err), 32'd0);
            got++;
         end
         if (req_ready) begin
            if (issued < nReq) begin
               s = 2'($urandom_range(0, 2));
               u = 1'($urandom);
               a = 32'h100 + 32'($urandom_range(0, 63));
               expQ.push_back(modelLoad(s, u, a));
               req_valid    = 1'b1;
               req_we       = 1'b0;
               req_size     = s;
               req_unsigned = u;
               req_addr     = a;
               issued++;
            end else begin
               req_valid = 1'b0;
            end
         end else begin
            req_we       = 1'($urandom);
            req_size     = 2'($urandom);
            req_unsigned = 1'($urandom);
            req_addr     = $urandom;
            req_wdata    = $urandom;
         end
         @(negedge clk);
         cyc++;
      end
      req_valid = 1'b0;
      checkOutput("b2b count", 32'(got), 32'(nReq));
      repeat (6) begin
         @(negedge clk);
         if (resp_valid) extra++;
      end
      checkOutput("b2b no extra", 32'(extra), 32'd0);
   endtask

   // Main sequence: reset values, test-plan cases, reset abort, streaming, random traffic.
   initial begin
      int          r;
      int          mism;
      logic [31:0] a;
      logic [1:0]  s;
      for (int i = 0; i < NBYTESM; i++) refBytes[i] = 8'($urandom);
      for (int w = 0; w < NWORDS; w++) memWords[w] = refWord(w);

      #12;
      checkOutput("reset ready", 32'(req_ready), 32'd1);
      checkOutput("reset resp_valid", 32'(resp_valid), 32'd0);
      checkOutput("reset resp_err", 32'(resp_err), 32'd0);
      checkOutput("reset rdata", resp_rdata, 32'd0);
      checkOutput("reset we", 32'(mem_we), 32'd0);
      checkOutput("reset mask", 32'(mem_wmask), 32'd0);
      checkOutput("reset addr", 32'(mem_addr), 32'd0);
      checkOutput("reset wdata", mem_wdata, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      applyStimulus("word st", 1'b1, 2'd2, 1'b0, 32'h100, 32'hDEADBEEF);
      checkOutput("word st addr", 32'(wrAddr[0]), 32'h40);
      checkOutput("word st mask", 32'(wrMask[0]), 32'hF);
      checkOutput("word st data", wrData[0], 32'hDEADBEEF);
      applyStimulus("word ld", 1'b0, 2'd2, 1'b0, 32'h100, 32'd0);
      checkOutput("word ld value", lastRdata, 32'hDEADBEEF);

      applyStimulus("byte st", 1'b1, 2'd0, 1'b0, 32'h203, 32'h80);
      checkOutput("byte st mask", 32'(wrMask[0]), 32'h8);
      checkOutput("byte st data", wrData[0], 32'h80000000);
      applyStimulus("byte lds", 1'b0, 2'd0, 1'b0, 32'h203, 32'd0);
      checkOutput("byte lds value", lastRdata, 32'hFFFFFF80);
      applyStimulus("byte ldu", 1'b0, 2'd0, 1'b1, 32'h203, 32'd0);
      checkOutput("byte ldu value", lastRdata, 32'h00000080);

      applyStimulus("split st", 1'b1, 2'd2, 1'b0, 32'h106, 32'h11223344);
      checkOutput("split st addr0", 32'(wrAddr[0]), 32'h41);
      checkOutput("split st mask0", 32'(wrMask[0]), 32'hC);
      checkOutput("split st data0", wrData[0], 32'h33440000);
      checkOutput("split st addr1", 32'(wrAddr[1]), 32'h42);
      checkOutput("split st mask1", 32'(wrMask[1]), 32'h3);
      checkOutput("split st data1", wrData[1], 32'h00001122);
      applyStimulus("split ld", 1'b0, 2'd2, 1'b0, 32'h106, 32'd0);
      checkOutput("split ld value", lastRdata, 32'h11223344);

      applyStimulus("fault size", 1'b1, 2'd3, 1'b0, 32'h100, 32'h12345678);
      checkOutput("fault size err", 32'(lastErr), 32'd1);
      applyStimulus("fault range", 1'b0, 2'd2, 1'b0, 32'h00020000, 32'd0);
      checkOutput("fault range err", 32'(lastErr), 32'd1);
      applyStimulus("fault last", 1'b1, 2'd2, 1'b0, 32'h1FFFE, 32'hCAFEF00D);
      checkOutput("fault last err", 32'(lastErr), 32'd1);
      checkOutput("fault last lat", 32'(lastLat), 32'd1);
      applyStimulus("last word ld", 1'b0, 2'd2, 1'b1, 32'h1FFFC, 32'd0);
      applyStimulus("half off1", 1'b1, 2'd1, 1'b0, 32'h111, 32'hBEEF);

      resetDuringSplit();
      backToBack(12);

      for (int k = 0; k < 300; k++) begin
         r = $urandom_range(0, 19);
         if (r == 0) a = $urandom;
         else if (r < 3) a = 32'h1FFF0 + 32'($urandom_range(0, 15));
         else a = 32'h100 + 32'($urandom_range(0, 63));
         s = (r == 3) ? 2'd3 : 2'($urandom_range(0, 2));
         applyStimulus("rand", 1'($urandom), s, 1'($urandom), a, $urandom);
      end

      mism = 0;
      for (int w = 0; w < NWORDS; w++)
         if (memWords[w] !== refWord(w)) mism++;
      checkOutput("memscan", 32'(mism), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
- Load/store sequencer between the core's MEM stage and the word-addressed, byte-masked data memory (combinational read, posedge write).
- Accepts one byte, half or word request at a time and converts the byte address into word address, byte write mask and lane-shifted write data.
- Splits accesses that cross a word boundary into two memory cycles, and sign- or zero-extends load data.
- Flags illegal sizes and out-of-range addresses without touching memory.

Parameters:
- ADDR_WIDTH, 15, word-address width of the data memory (memory holds 2^ADDR_WIDTH words).
- DATA_WIDTH, 32, data width; fixed at 32 (4 byte lanes).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  controller can accept a request
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  0 byte, 1 half, 2 word, 3 illegal
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned
- resp_valid  out  1  one-cycle completion pulse
- resp_err  out  1  valid with resp_valid: request faulted
- resp_rdata  out  32  extended load data, valid with resp_valid
- mem_addr  out  ADDR_WIDTH  word address to data memory
- mem_wdata  out  32  lane-aligned write data
- mem_wmask  out  4  byte write enables
- mem_we  out  1  write strobe
- mem_rdata  in  32  combinational read data from memory

Behaviour:
- Reset: state IDLE. All outputs 0 except req_ready=1. An in-flight access is abandoned; no write is issued after reset asserts.
- States: IDLE, ACC0, ACC1, DONE.
- IDLE:
  - req_ready=1. On req_valid, the request is captured into registers.
  - Next state is ACC0, or DONE with error if the request faults.
- Derived values: off = addr[1:0]; n = 1/2/4 bytes; span = (off+n > 4); w0 = addr[ADDR_WIDTH+1:2].
- Faults (resp_err=1, no memory cycle, IDLE -> DONE):
  - req_size=3.
  - addr[31:ADDR_WIDTH+2] != 0.
  - span=1 with w0 equal to the last word (no wrap-around to word 0).
- ACC0:
  - mem_addr=w0.
  - Store: mem_we=1; mem_wmask=(((1<<n)-1)<<off)[3:0]; mem_wdata=req_wdata<<(8*off).
  - Load: mem_we=0, mem_wmask=0; mem_rdata is captured as lo.
  - Next state is ACC1 if span, else DONE.
- ACC1:
  - mem_addr=w0+1.
  - Store: mask=((1<<n)-1)>>(4-off); data=req_wdata>>(8*(4-off)).
  - Load: mem_rdata is captured as hi. Next state DONE.
- DONE:
  - resp_valid=1 for exactly one cycle.
  - Load: resp_rdata = low n bytes of ({hi,lo}>>(8*off)), extended per req_unsigned to 32 bits. hi=0 when span=0.
  - Store or error: resp_rdata=0.
  - Next state IDLE.
- Outside ACC0/ACC1: mem_we=0, mem_wmask=0, and mem_addr holds its last value.
- Latency from the accepting edge to resp_valid: aligned 2 cycles, split 3 cycles, fault 1 cycle.
- Throughput: req_ready=0 in ACC0, ACC1 and DONE. No request is accepted in the same cycle that resp_valid is high; the next request is accepted in the following IDLE cycle.
- No backpressure on the response; the consumer must take resp_valid when it is pulsed.
- Request inputs are sampled only on the accepting edge; later changes have no effect on the access in flight.
- Misaligned accesses that stay within one word (e.g. half at off=1) complete in one memory cycle.

Test Plan:
- Word store addr=0x100, data=0xDEADBEEF, then word load addr=0x100 -> ACC0 has mem_addr=0x40 and mask=1111; load returns 0xDEADBEEF with resp_err=0 two cycles after acceptance.
- Byte store data=0x80 at 0x203, then signed and unsigned byte loads at 0x203:
  - store has mask=1000, mem_wdata=0x80000000;
  - signed load returns 0xFFFFFF80, unsigned load returns 0x00000080.
- Split word store 0x11223344 at addr=0x106:
  - ACC0: mem_addr=0x41, mask=1100, data=0x33440000;
  - ACC1: mem_addr=0x42, mask=0011, data=0x00001122.
  - A word load at 0x106 returns 0x11223344 three cycles after acceptance.
- Faults, each giving resp_err=1 one cycle after acceptance with mem_we never asserted:
  - req_size=3;
  - req_addr=0x00020000 with ADDR_WIDTH=15;
  - word access at 0x1FFFE (split from the last word).
- Assert rst_n low during ACC0 of a split store -> outputs immediately return to reset values; ACC1's write is never issued and the second word is unchanged.
- Hold req_valid high for back-to-back loads -> each is accepted only while req_ready=1; resp_valid pulses once per request, with no overlap and no dropped requests.
